msi_bus_initiator: RTL

Bus-side initiator of the MSI snoopy cache. It takes a miss or upgrade request from the cache's CPU-side controller, together with that controller's writeBackRequired, invalidateRequired and readExclusiveRequired decisions, and then:
- arbitrates for the shared bus;
- writes back a dirty victim line, if required;
- issues BUS_READ, BUS_READ_EXCLUSIVE or BUS_INVALIDATE on the bus, which peer caches snoop;
- fills the line into the data array.

---
 rtl/msi_bus_initiator_pkg.sv | 22 ++
 rtl/msi_block_word_counter.sv | 26 ++
 rtl/msi_bus_initiator.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/msi_bus_initiator_pkg.sv
// Shared bus command encoding and the bus initiator's FSM state encoding.
// Two packages: commands is also imported by the snoop-side protocol tables.

package commands;
  typedef enum logic [1:0] {
    NONE               = 2'd0,
    BUS_READ           = 2'd1,
    BUS_READ_EXCLUSIVE = 2'd2,
    BUS_INVALIDATE     = 2'd3
  } command_t;
endpackage

package msi_bus_initiator_states;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARBITRATE  = 3'd1,
    WRITE_BACK = 3'd2,
    FETCH      = 3'd3,
    INVALIDATE = 3'd4,
    DONE       = 3'd5
  } state_t;
endpackage

// File: rtl/msi_block_word_counter.sv
// Word counter across one cache line; wraps to 0 only after the last word.

module msi_block_word_counter #(
  parameter  int BLOCK_WORDS = 4,
  localparam int WIDTH       = $clog2(BLOCK_WORDS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  assign last = (count == WIDTH'(BLOCK_WORDS - 1));

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= last ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/msi_bus_initiator.sv
// Bus-side initiator of the MSI snoopy cache: arbitrate, write back, fetch or invalidate.
// Optional MSI_BUS_INITIATOR_STATS_EN adds saturating per-kind transaction counters.

module msi_bus_initiator
  import commands::*;
  import msi_bus_initiator_states::*;
#(
  parameter  int ADDRESS_WIDTH = 32,
  parameter  int DATA_WIDTH    = 32,
  parameter  int BLOCK_WORDS   = 4,
  localparam int INDEX_WIDTH   = $clog2(BLOCK_WORDS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     missValid,
  input  logic [ADDRESS_WIDTH-1:0] missAddress,
  input  logic                     writeBackRequired,
  input  logic [ADDRESS_WIDTH-1:0] writeBackAddress,
  input  logic                     invalidateRequired,
  input  logic                     readExclusiveRequired,
  output logic                     done,
  output logic [INDEX_WIDTH-1:0]   cacheWordIndex,
  input  logic [DATA_WIDTH-1:0]    cacheReadData,
  output logic [DATA_WIDTH-1:0]    cacheWriteData,
  output logic                     cacheWriteEnable,
  output logic                     busRequest,
  input  logic                     busGrant,
  output command_t                 busCommand,
  output logic [ADDRESS_WIDTH-1:0] busAddress,
  output logic                     busRead,
  output logic                     busWrite,
  output logic [DATA_WIDTH-1:0]    busDataOut,
  input  logic [DATA_WIDTH-1:0]    busDataIn,
  input  logic                     busAck
`ifdef MSI_BUS_INITIATOR_STATS_EN
  ,
  output logic [15:0]              fetchCount,
  output logic [15:0]              writeBackCount,
  output logic [15:0]              invalidateCount
`endif
);

  localparam int OFFSET_BITS = $clog2(BLOCK_WORDS * DATA_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK =
    ADDRESS_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] missAddressQ;
  logic [ADDRESS_WIDTH-1:0] writeBackAddressQ;
  logic                     writeBackQ;
  logic                     invalidateQ;
  logic                     readExclusiveQ;

  logic [INDEX_WIDTH-1:0]   wordCount;
  logic                     wordLast;
  logic                     wordAccepted;

  // A word moves only while we still own the bus; a late ack after grant loss is ignored.
  assign wordAccepted = busGrant && busAck && (state == WRITE_BACK || state == FETCH);

  msi_block_word_counter #(.BLOCK_WORDS(BLOCK_WORDS)) wordCounter (
    .clock  (clock),
    .reset  (reset),
    .enable (wordAccepted),
    .clear  (state == IDLE),
    .count  (wordCount),
    .last   (wordLast)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= IDLE;
      missAddressQ      <= '0;
      writeBackAddressQ <= '0;
      writeBackQ        <= 1'b0;
      invalidateQ       <= 1'b0;
      readExclusiveQ    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (missValid) begin
            missAddressQ      <= missAddress & ~OFFSET_MASK;
            writeBackAddressQ <= writeBackAddress & ~OFFSET_MASK;
            writeBackQ        <= writeBackRequired;
            invalidateQ       <= invalidateRequired;
            readExclusiveQ    <= readExclusiveRequired;
            state             <= ARBITRATE;
          end
        end
        ARBITRATE: begin
          if (busGrant) begin
            if (invalidateQ)     state <= INVALIDATE;
            else if (writeBackQ) state <= WRITE_BACK;
            else                 state <= FETCH;
          end
        end
        WRITE_BACK: if (wordAccepted && wordLast) state <= FETCH;
        FETCH:      if (wordAccepted && wordLast) state <= DONE;
        INVALIDATE: if (busGrant && busAck)       state <= DONE;
        DONE:       state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    done             = 1'b0;
    busRequest       = 1'b0;
    busCommand       = NONE;
    busAddress       = '0;
    busRead          = 1'b0;
    busWrite         = 1'b0;
    busDataOut       = '0;
    cacheWordIndex   = '0;
    cacheWriteData   = '0;
    cacheWriteEnable = 1'b0;
    case (state)
      ARBITRATE: busRequest = 1'b1;
      WRITE_BACK: begin
        busRequest     = 1'b1;
        busAddress     = writeBackAddressQ;
        busWrite       = busGrant;
        cacheWordIndex = wordCount;
        busDataOut     = cacheReadData;
      end
      FETCH: begin
        busRequest     = 1'b1;
        busCommand     = readExclusiveQ ? BUS_READ_EXCLUSIVE : BUS_READ;
        busAddress     = missAddressQ;
        busRead        = busGrant;
        cacheWordIndex = wordCount;
        if (busGrant && busAck) begin
          cacheWriteEnable = 1'b1;
          cacheWriteData   = busDataIn;
        end
      end
      INVALIDATE: begin
        busRequest = 1'b1;
        busCommand = BUS_INVALIDATE;
        busAddress = missAddressQ;
      end
      DONE: begin
        busRequest = 1'b1;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MSI_BUS_INITIATOR_STATS_EN
  logic fetchFinished;
  logic writeBackFinished;
  logic invalidateFinished;

  assign fetchFinished      = wordAccepted && wordLast && (state == FETCH);
  assign writeBackFinished  = wordAccepted && wordLast && (state == WRITE_BACK);
  assign invalidateFinished = busGrant && busAck && (state == INVALIDATE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetchCount      <= '0;
      writeBackCount  <= '0;
      invalidateCount <= '0;
    end else begin
      if (fetchFinished && fetchCount != 16'hFFFF)
        fetchCount <= fetchCount + 16'd1;
      if (writeBackFinished && writeBackCount != 16'hFFFF)
        writeBackCount <= writeBackCount + 16'd1;
      if (invalidateFinished && invalidateCount != 16'hFFFF)
        invalidateCount <= invalidateCount + 16'd1;
    end
  end
`endif

endmodule
